// File: rtl/exe_unit_seq.sv
// Handshaked execution unit: single-cycle ADD/CMP/SET/CONV and an iterative
// shift-add MUL, with the registered result held until the consumer takes it.
module exe_unit_seq #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [2:0]       i_oper,
    input  logic [WIDTH-1:0] i_argA,
    input  logic [WIDTH-1:0] i_argB,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_result,
    output logic             o_error,
    output logic             o_carry
);

    localparam int SW = $clog2(WIDTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_CMP  = 3'd1;
    localparam logic [2:0] OP_SET  = 3'd2;
    localparam logic [2:0] OP_CONV = 3'd3;
    localparam logic [2:0] OP_MUL  = 3'd4;

    logic [1:0]         r_state;
    logic [WIDTH-1:0]   r_a;
    logic [2*WIDTH-1:0] r_acc;
    logic [SW-1:0]      r_cnt;
    logic [WIDTH-1:0]   r_result;
    logic               r_error;
    logic               r_carry;

    logic [WIDTH:0]     w_add;
    logic [WIDTH-1:0]   w_neg;
    logic [WIDTH-1:0]   w_res;
    logic               w_err;
    logic               w_cry;
    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH-1:0] w_acc_next;

    assign w_add = {1'b0, i_argA} + {1'b0, i_argB};
    assign w_neg = -i_argA;

    // Single-cycle ops are evaluated from the request itself so the result
    // is registered on the same edge that accepts it.
    always_comb begin
        w_res = '0;
        w_err = 1'b0;
        w_cry = 1'b0;
        case (i_oper)
            OP_ADD: begin
                w_res = w_add[WIDTH-1:0];
                w_cry = w_add[WIDTH];
            end
            OP_CMP: begin
                w_res[0] = (i_argA == i_argB);
                w_res[1] = (i_argA < i_argB);
                w_res[2] = ($signed(i_argA) < $signed(i_argB));
            end
            OP_SET: begin
                if (i_argB < WIDTH'(WIDTH)) begin
                    w_res = i_argA | (WIDTH'(1) << i_argB[SW-1:0]);
                end else begin
                    w_res = i_argA;
                    w_err = 1'b1;
                end
            end
            OP_CONV: begin
                if (!i_argA[WIDTH-1]) begin
                    w_res = i_argA;
                end else if (i_argA[WIDTH-2:0] == '0) begin
                    w_res = i_argA;
                    w_err = 1'b1;
                end else begin
                    w_res = w_neg | {1'b1, {(WIDTH-1){1'b0}}};
                end
            end
            OP_MUL: begin
                w_res = '0;
            end
            default: begin
                w_err = 1'b1;
            end
        endcase
    end

    // Accumulator holds {partial product, remaining multiplier bits}; each step
    // adds A into the upper half when the current B bit is set, then shifts right.
    assign w_sum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_a} : '0);
    assign w_acc_next = {w_sum, r_acc[WIDTH-1:1]};

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_state  <= S_IDLE;
            r_a      <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_error  <= 1'b0;
            r_carry  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_valid) begin
                        r_a   <= i_argA;
                        r_acc <= {{WIDTH{1'b0}}, i_argB};
                        r_cnt <= '0;
                        if (i_oper == OP_MUL) begin
                            r_state <= S_BUSY;
                        end else begin
                            r_state  <= S_DONE;
                            r_result <= w_res;
                            r_error  <= w_err;
                            r_carry  <= w_cry;
                        end
                    end
                end
                S_BUSY: begin
                    r_acc <= w_acc_next;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == SW'(WIDTH-1)) begin
                        r_state  <= S_DONE;
                        r_result <= w_acc_next[WIDTH-1:0];
                        r_error  <= 1'b0;
                        r_carry  <= |w_acc_next[2*WIDTH-1:WIDTH];
                    end
                end
                S_DONE: begin
                    if (i_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_ready  = (r_state == S_IDLE);
    assign o_valid  = (r_state == S_DONE);
    assign o_result = r_result;
    assign o_error  = r_error;
    assign o_carry  = r_carry;

endmodule

// File: tb/tb_exe_unit_seq.sv
// Bench for exe_unit_seq at WIDTH 32, 4 and 64: directed cases plus random
// operations checked against an arithmetic reference model.
module tb_exe_unit_seq;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn;
    logic [2:0]  vld, rdy, ordy, oval, oerr, ocry;
    logic [2:0]  oper;
    logic [63:0] arga, argb;
    logic [31:0] res32;
    logic [3:0]  res4;
    logic [63:0] res64;

    int tests = 0;
    int fails = 0;

    exe_unit_seq #(.WIDTH(32)) u_w32 (
        .i_clk(clk), .i_rstn(rstn), .i_valid(vld[0]), .o_ready(ordy[0]),
        .i_oper(oper), .i_argA(arga[31:0]), .i_argB(argb[31:0]),
        .o_valid(oval[0]), .i_ready(rdy[0]), .o_result(res32),
        .o_error(oerr[0]), .o_carry(ocry[0])
    );

    exe_unit_seq #(.WIDTH(4)) u_w4 (
        .i_clk(clk), .i_rstn(rstn), .i_valid(vld[1]), .o_ready(ordy[1]),
        .i_oper(oper), .i_argA(arga[3:0]), .i_argB(argb[3:0]),
        .o_valid(oval[1]), .i_ready(rdy[1]), .o_result(res4),
        .o_error(oerr[1]), .o_carry(ocry[1])
    );

    exe_unit_seq #(.WIDTH(64)) u_w64 (
        .i_clk(clk), .i_rstn(rstn), .i_valid(vld[2]), .o_ready(ordy[2]),
        .i_oper(oper), .i_argA(arga), .i_argB(argb),
        .o_valid(oval[2]), .i_ready(rdy[2]), .o_result(res64),
        .o_error(oerr[2]), .o_carry(ocry[2])
    );

    function automatic int width_of(input int k);
        return (k == 0) ? 32 : (k == 1) ? 4 : 64;
    endfunction

    function automatic logic [63:0] res_of(input int k);
        if (k == 0) return {32'b0, res32};
        if (k == 1) return {60'b0, res4};
        return res64;
    endfunction

    // Reference model: plain unbounded-style arithmetic on 128-bit values.
    function automatic void model(input int w, input logic [2:0] op,
                                  input logic [63:0] a_in, input logic [63:0] b_in,
                                  output logic [63:0] r, output logic e, output logic c);
        logic [127:0] m, a, b, full, half;
        m    = (128'd1 << w) - 128'd1;
        a    = {64'b0, a_in} & m;
        b    = {64'b0, b_in} & m;
        half = 128'd1 << (w - 1);
        r = '0; e = 1'b0; c = 1'b0;
        case (op)
            3'd0: begin
                full = a + b;
                r = 64'(full & m);
                c = ((full >> w) != 128'd0);
            end
            3'd1: begin
                r[0] = (a == b);
                r[1] = (a < b);
                if (a[w-1] != b[w-1]) r[2] = a[w-1];
                else                  r[2] = (a < b);
            end
            3'd2: begin
                if (b < 128'(w)) r = 64'((a | (128'd1 << b)) & m);
                else begin r = 64'(a); e = 1'b1; end
            end
            3'd3: begin
                if (a < half)       r = 64'(a);
                else if (a == half) begin r = 64'(a); e = 1'b1; end
                else                r = 64'(half | ((m + 128'd1) - a));
            end
            3'd4: begin
                full = a * b;
                r = 64'(full & m);
                c = ((full >> w) != 128'd0);
            end
            default: e = 1'b1;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Presents one request at a negedge and waits (bounded) for o_valid.
    // Operands are scrambled after acceptance to show they are not re-read.
    task automatic issue(input int k, input logic [2:0] op, input logic [63:0] a,
                         input logic [63:0] b, output int lat, output logic busy_ok);
        vld[k] = 1'b1; oper = op; arga = a; argb = b;
        lat = 0; busy_ok = 1'b1;
        for (int n = 0; n < 100; n++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            vld[k] = 1'b0;
            arga = {$urandom, $urandom};
            argb = {$urandom, $urandom};
            if (oval[k]) break;
            if (ordy[k]) busy_ok = 1'b0;
        end
    endtask

    task automatic drain(input int k, input string tag);
        rdy[k] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rdy[k] = 1'b0;
        chk({tag, ".valid_after_drain"}, 64'(oval[k]), 64'd0);
        chk({tag, ".ready_after_drain"}, 64'(ordy[k]), 64'd1);
    endtask

    task automatic txn(input int k, input logic [2:0] op, input logic [63:0] a,
                       input logic [63:0] b, input string tag);
        int          lat;
        logic        busy_ok;
        logic [63:0] er;
        logic        ee, ec;
        int          w;
        w = width_of(k);
        model(w, op, a, b, er, ee, ec);
        issue(k, op, a, b, lat, busy_ok);
        chk({tag, ".latency"}, 64'(lat), (op == 3'd4) ? 64'(w + 1) : 64'd1);
        chk({tag, ".result"},  res_of(k), er);
        chk({tag, ".error"},   64'(oerr[k]), 64'(ee));
        chk({tag, ".carry"},   64'(ocry[k]), 64'(ec));
        chk({tag, ".no_ready_busy"}, 64'(busy_ok), 64'd1);
        chk({tag, ".no_ready_done"}, 64'(ordy[k]), 64'd0);
        $display("[TB] %s w=%0d op=%0d a=%h b=%h res=%h err=%0b cry=%0b lat=%0d",
                 tag, w, op, a, b, res_of(k), oerr[k], ocry[k], lat);
        drain(k, tag);
    endtask

    initial begin
        int          lat;
        logic        busy_ok;
        logic [63:0] er;
        logic        ee, ec;

        rstn = 1'b0; vld = '0; rdy = '0; oper = '0; arga = '0; argb = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        for (int k = 0; k < 3; k++) begin
            chk("reset.valid",  64'(oval[k]), 64'd0);
            chk("reset.ready",  64'(ordy[k]), 64'd1);
            chk("reset.result", res_of(k), 64'd0);
            chk("reset.error",  64'(oerr[k]), 64'd0);
        end

        txn(0, 3'd0, 64'hFFFF_FFFF, 64'd1, "add_wrap");
        txn(0, 3'd2, 64'h0, 64'd5, "set_b5");
        txn(0, 3'd2, 64'h1234, 64'd40, "set_b40");
        txn(0, 3'd3, 64'hFFFF_FFFF, 64'd0, "conv_m1");
        txn(0, 3'd3, 64'h8000_0000, 64'd0, "conv_min");
        txn(0, 3'd3, 64'h0000_1234, 64'd0, "conv_pos");
        txn(0, 3'd4, 64'h1_0000, 64'h1_0000, "mul_ovf");
        txn(0, 3'd4, 64'd7, 64'd6, "mul_7x6");
        txn(0, 3'd6, 64'h55, 64'h66, "illegal6");

        // Backpressure: result held while i_ready=0 and new requests ignored.
        model(32, 3'd1, 64'd3, 64'hFFFF_FFFF, er, ee, ec);
        issue(0, 3'd1, 64'd3, 64'hFFFF_FFFF, lat, busy_ok);
        chk("bp.result", res_of(0), er);
        $display("[TB] bp_cmp res=%h lat=%0d", res_of(0), lat);
        vld[0] = 1'b1; oper = 3'd0; arga = 64'd1; argb = 64'd1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("bp.hold_result", res_of(0), er);
            chk("bp.hold_valid",  64'(oval[0]), 64'd1);
            chk("bp.hold_ready",  64'(ordy[0]), 64'd0);
        end
        rdy[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rdy[0] = 1'b0;
        chk("bp.drain_valid", 64'(oval[0]), 64'd0);
        chk("bp.drain_ready", 64'(ordy[0]), 64'd1);
        @(posedge clk);
        @(negedge clk);
        vld[0] = 1'b0;
        chk("bp.next_accept_valid",  64'(oval[0]), 64'd1);
        chk("bp.next_accept_result", res_of(0), 64'd2);
        $display("[TB] bp_next_add res=%h", res_of(0));
        drain(0, "bp_next");

        // Reset in the middle of a multiply aborts it.
        vld[0] = 1'b1; oper = 3'd4; arga = 64'd123456; argb = 64'd789;
        @(posedge clk);
        @(negedge clk);
        vld[0] = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        rstn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        chk("midrst.valid",  64'(oval[0]), 64'd0);
        chk("midrst.ready",  64'(ordy[0]), 64'd1);
        chk("midrst.result", res_of(0), 64'd0);
        chk("midrst.error",  64'(oerr[0]), 64'd0);
        chk("midrst.carry",  64'(ocry[0]), 64'd0);
        repeat (40) @(negedge clk);
        chk("midrst.no_late_valid", 64'(oval[0]), 64'd0);
        $display("[TB] midrst aborted mul");
        txn(0, 3'd0, 64'd2, 64'd3, "add_after_rst");

        for (int i = 0; i < 20; i++)
            txn(0, 3'($urandom_range(0, 7)), {32'b0, $urandom},
                {32'b0, (i % 2 == 0) ? 32'($urandom_range(0, 40)) : $urandom}, "rnd32");
        for (int i = 0; i < 30; i++)
            txn(1, ($urandom_range(0, 1) == 1) ? 3'd4 : 3'd0,
                64'($urandom_range(0, 15)), 64'($urandom_range(0, 15)), "rnd4");
        for (int i = 0; i < 30; i++)
            txn(2, ($urandom_range(0, 1) == 1) ? 3'd4 : 3'd0,
                {$urandom, $urandom}, (i % 3 == 0) ? 64'($urandom) : {$urandom, $urandom}, "rnd64");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
